sync_fifo_sdpram: RTL and testbench



---
 rtl/sync_fifo_sdpram_if.sv | 31 +++
 rtl/sync_fifo_sdpram.sv | 125 ++++++++++++
 tb/tb_sync_fifo_sdpram.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_sdpram_if.sv
// Handshake and status bundle for sync_fifo_sdpram.
// master = producer/consumer side, slave = the FIFO itself.
interface sync_fifo_sdpram_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 10
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_valid;
  logic                  empty;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_sdpram.sv
// Single-clock FIFO on an inferred simple dual-port RAM with count, almost flags and sticky errors.
// Define FIFO_OUTPUT_REG_EN to add an output register after the RAM read port (read latency 2).
module sync_fifo_sdpram #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 10,
  parameter int AFULL_THRESH  = 1020,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  sync_fifo_sdpram_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int CNT_W = ADDR_WIDTH + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AFULL_C = CNT_W'(AFULL_THRESH);
  localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  afull_q, afull_d;
  logic                  aempty_q, aempty_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_acc, rd_acc;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] ram_rd_q;

  // Flags are computed from next-count so they land in the same cycle as count.
  always_comb begin
    wr_acc      = bus.wr_en & ~full_q;
    rd_acc      = bus.rd_en & ~empty_q;
    wr_ptr_d    = wr_ptr_q + ADDR_WIDTH'(wr_acc);
    rd_ptr_d    = rd_ptr_q + ADDR_WIDTH'(rd_acc);
    count_d     = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    full_d      = (count_d == DEPTH_C);
    empty_d     = (count_d == '0);
    afull_d     = (count_d >= AFULL_C);
    aempty_d    = (count_d <= AEMPTY_C);
    overflow_d  = overflow_q | (bus.wr_en & full_q);
    underflow_d = underflow_q | (bus.rd_en & empty_q);
    rd_valid_d  = rd_acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      afull_q     <= 1'b0;
      aempty_q    <= 1'b1;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      afull_q     <= afull_d;
      aempty_q    <= aempty_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  // RAM storage: never reset, so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (rst_n && wr_acc) begin
      mem[wr_ptr_q] <= bus.wr_data;
    end
  end

  // Read kept inside the clocked block so the RAM's own output register is used.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_rd_q <= '0;
    end else if (rd_acc) begin
      ram_rd_q <= mem[rd_ptr_q];
    end
  end

`ifdef FIFO_OUTPUT_REG_EN
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_valid_q, out_valid_d;

  always_comb begin
    out_valid_d = rd_valid_q;
    out_data_d  = rd_valid_q ? ram_rd_q : out_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.rd_data  = out_data_q;
  assign bus.rd_valid = out_valid_q;
`else
  assign bus.rd_data  = ram_rd_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = afull_q;
  assign bus.almost_empty = aempty_q;
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_sdpram.sv
// Randomised self-checking bench for sync_fifo_sdpram against a queue-based reference model.
// Honours FIFO_OUTPUT_REG_EN for the expected read latency.
module tb_sync_fifo_sdpram;
  localparam int DW    = 8;
  localparam int AW    = 10;
  localparam int DEPTH = 1 << AW;
  localparam int AFT   = 1020;
  localparam int AET   = 4;
`ifdef FIFO_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_sdpram_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  sync_fifo_sdpram #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AFULL_THRESH(AFT), .AEMPTY_THRESH(AET)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit            m_ov, m_un;
  bit            exp_v;
  logic [DW-1:0] exp_d;
  bit            st_v;
  logic [DW-1:0] st_d;
  bit            last_rd_acc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, compare 1 time unit later.
  task automatic step(input bit rst, input bit wr, input logic [DW-1:0] wd, input bit rd);
    bit            wa, ra, nv;
    logic [DW-1:0] nd;
    rst_n       = ~rst;
    bus.wr_en   = wr;
    bus.wr_data = wd;
    bus.rd_en   = rd;
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ov = 0; m_un = 0;
      exp_v = 0; exp_d = '0; st_v = 0; st_d = '0;
      last_rd_acc = 0;
    end else begin
      wa = wr && (q.size() < DEPTH);
      ra = rd && (q.size() > 0);
      if (wr && !wa) m_ov = 1;
      if (rd && !ra) m_un = 1;
      nv = ra;
      nd = ra ? q.pop_front() : '0;
      if (wa) q.push_back(wd);
      if (LAT == 2) begin
        exp_v = st_v;
        if (st_v) exp_d = st_d;
        st_v = nv;
        st_d = nd;
      end else begin
        exp_v = nv;
        if (nv) exp_d = nd;
      end
      last_rd_acc = ra;
    end
    #1;
    check("count",        32'(bus.count),        32'(q.size()));
    check("full",         32'(bus.full),         32'(q.size() == DEPTH));
    check("empty",        32'(bus.empty),        32'(q.size() == 0));
    check("almost_full",  32'(bus.almost_full),  32'(q.size() >= AFT));
    check("almost_empty", 32'(bus.almost_empty), 32'(q.size() <= AET));
    check("overflow",     32'(bus.overflow),     32'(m_ov));
    check("underflow",    32'(bus.underflow),    32'(m_un));
    check("rd_valid",     32'(bus.rd_valid),     32'(exp_v));
    check("rd_data",      32'(bus.rd_data),      32'(exp_d));
  endtask

  initial begin
    logic [DW-1:0] ctr;
    bit            wr, rd;
    bus.wr_en = 0; bus.wr_data = '0; bus.rd_en = 0;
    q.delete(); m_ov = 0; m_un = 0; exp_v = 0; exp_d = '0; st_v = 0; st_d = '0;
    last_rd_acc = 0;

    // Reset then fill with 0xFF down to 0x00, repeating
    for (int i = 0; i < 20; i++) step(1, 0, '0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(8'hFF - (i & 8'hFF)), 0);
    check("fill_full", 32'(bus.full), 32'd1);
    check("fill_count", 32'(bus.count), 32'(DEPTH));
    step(0, 1, 8'h77, 0);
    check("fill_ovf", 32'(bus.overflow), 32'd1);

    // Drain, then one read too many
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1);
    for (int i = 1; i < LAT; i++) step(0, 0, '0, 0);
    check("drain_empty", 32'(bus.empty), 32'd1);
    step(0, 0, '0, 1);
    check("drain_unf", 32'(bus.underflow), 32'd1);
    for (int i = 0; i < LAT; i++) step(0, 0, '0, 0);

    // Simultaneous read/write at full, then at empty
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'($urandom), 0);
    step(0, 1, 8'h11, 1);
    check("sim_full_cnt", 32'(bus.count), 32'(DEPTH - 1));
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, '0, 1);
    for (int i = 0; i < LAT; i++) step(0, 0, '0, 0);
    step(0, 1, 8'hA5, 1);
    check("sim_empty_cnt", 32'(bus.count), 32'd1);
    for (int i = 0; i < LAT; i++) step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    for (int i = 0; i < LAT; i++) step(0, 0, '0, 0);
    check("sim_empty_a5", 32'(bus.rd_data), 32'h0A5);

    // Wrap-around streaming with low occupancy and incrementing data
    ctr = '0;
    for (int i = 0; i < 3000; i++) begin
      wr = (q.size() < 4) && ($urandom_range(0, 7) != 0);
      rd = (q.size() >= 2) || ($urandom_range(0, 3) == 0);
      step(0, wr, ctr, rd);
      if (wr) ctr++;
      check("stream_cnt_le4", 32'(bus.count <= 4), 32'd1);
    end
    for (int i = 0; i < 8; i++) step(0, 0, '0, 1);

    // Free random traffic across the whole range
    for (int i = 0; i < 1500; i++)
      step(0, $urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 2) == 0);

    // Reset mid-stream at count 500 with a read in flight
    step(1, 0, '0, 0);
    for (int i = 0; i < 500; i++) step(0, 1, DW'($urandom), 0);
    step(0, 1, DW'($urandom), 1);
    step(1, 1, 8'h99, 1);
    check("mid_rst_cnt", 32'(bus.count), 32'd0);
    check("mid_rst_valid", 32'(bus.rd_valid), 32'd0);
    step(0, 1, 8'h3C, 0);
    step(0, 0, '0, 1);
    for (int i = 0; i < LAT; i++) step(0, 0, '0, 0);
    check("mid_rst_3c", 32'(bus.rd_data), 32'h03C);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
